// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline stall/flush and operand forwarding controller
// Vector memory ops hold the whole pipe; branch and load-use are resolved only when it is free.
module hazard_unit #(
  parameter int M    = 4,
  parameter int VLAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] regAD,
  input  logic [M-1:0] regBD,
  input  logic [M-1:0] regAE,
  input  logic [M-1:0] regBE,
  input  logic [M-1:0] regScr_E,
  input  logic         regw_E,
  input  logic         regmem_E,
  input  logic         branch_E,
  input  logic         taken_E,
  input  logic [M-1:0] regScr_M,
  input  logic         regw_M,
  input  logic         vect_M,
  input  logic         memop_M,
  input  logic [M-1:0] regScr_W,
  input  logic         regw_W,
  output logic         stall_F,
  output logic         stall_D,
  output logic         stall_E,
  output logic         stall_M,
  output logic         flush_D,
  output logic         flush_E,
  output logic         flush_W,
  output logic [1:0]   fwdA_E,
  output logic [1:0]   fwdB_E
);

  localparam int            CW       = (VLAT > 1) ? $clog2(VLAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((VLAT > 1) ? VLAT - 2 : 0);
  localparam logic          VEN      = (VLAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          vstart, vstall, load_use, br_taken;

  assign vstart   = (state_q == IDLE) && vect_M && memop_M && VEN;
  assign vstall   = vstart || ((state_q == BUSY) && (cnt_q != '0));
  assign load_use = regmem_E && regw_E && ((regScr_E == regAD) || (regScr_E == regBD));
  assign br_taken = branch_E && taken_E;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (vstart) begin
      state_d = BUSY;
      cnt_d   = CNT_INIT;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority: reset, vector memory hold, taken branch, load-use bubble.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (!rst) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
      flush_W = 1'b1;
    end else if (vstall) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
      flush_W = 1'b1;
    end else if (br_taken) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  always_comb begin
    fwdA_E = 2'b00;
    fwdB_E = 2'b00;
    if (rst) begin
      if (regw_M && (regScr_M == regAE))      fwdA_E = 2'b10;
      else if (regw_W && (regScr_W == regAE)) fwdA_E = 2'b01;
      if (regw_M && (regScr_M == regBE))      fwdB_E = 2'b10;
      else if (regw_W && (regScr_W == regBE)) fwdB_E = 2'b01;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector bench for hazard_unit
// Ctl vector order: {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}.
module tb_hazard_unit;

  localparam int M = 4;

  typedef struct {
    string      name;
    logic       rst;
    logic [M-1:0] ad, bd, ae, be, se, sm, sw;
    logic       rwe, rme, br, tk, rwm, vm, mm, rww;
    logic [6:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_VM   = 7'b1111001;
  localparam logic [6:0] C_RST  = 7'b0000111;

  logic clk = 1'b0;
  logic rst;
  logic [M-1:0] regAD, regBD, regAE, regBE, regScr_E, regScr_M, regScr_W;
  logic regw_E, regmem_E, branch_E, taken_E, regw_M, vect_M, memop_M, regw_W;
  logic stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
  logic [1:0] fwdA_E, fwdB_E;
  logic s1_F, s1_D, s1_E, s1_M, f1_D, f1_E, f1_W;
  logic [1:0] fa1, fb1;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];
  vec_t v;

  always #5 clk = ~clk;

  hazard_unit #(.M(M), .VLAT(4)) dut (
    .clk(clk), .rst(rst), .regAD(regAD), .regBD(regBD), .regAE(regAE), .regBE(regBE),
    .regScr_E(regScr_E), .regw_E(regw_E), .regmem_E(regmem_E), .branch_E(branch_E),
    .taken_E(taken_E), .regScr_M(regScr_M), .regw_M(regw_M), .vect_M(vect_M),
    .memop_M(memop_M), .regScr_W(regScr_W), .regw_W(regw_W),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W), .fwdA_E(fwdA_E), .fwdB_E(fwdB_E)
  );

  hazard_unit #(.M(M), .VLAT(1)) dut1 (
    .clk(clk), .rst(rst), .regAD(regAD), .regBD(regBD), .regAE(regAE), .regBE(regBE),
    .regScr_E(regScr_E), .regw_E(regw_E), .regmem_E(regmem_E), .branch_E(branch_E),
    .taken_E(taken_E), .regScr_M(regScr_M), .regw_M(regw_M), .vect_M(vect_M),
    .memop_M(memop_M), .regScr_W(regScr_W), .regw_W(regw_W),
    .stall_F(s1_F), .stall_D(s1_D), .stall_E(s1_E), .stall_M(s1_M),
    .flush_D(f1_D), .flush_E(f1_E), .flush_W(f1_W), .fwdA_E(fa1), .fwdB_E(fb1)
  );

  function automatic vec_t dflt(string name);
    vec_t d;
    d.name = name; d.rst = 1'b1;
    d.ad = 4'd1; d.bd = 4'd2; d.ae = 4'd7; d.be = 4'd8;
    d.se = 4'd9; d.sm = 4'd10; d.sw = 4'd11;
    d.rwe = 0; d.rme = 0; d.br = 0; d.tk = 0; d.rwm = 0; d.vm = 0; d.mm = 0; d.rww = 0;
    d.ctl = C_NONE; d.fa = 2'b00; d.fb = 2'b00;
    return d;
  endfunction

  task automatic drive(input vec_t x);
    rst = x.rst; regAD = x.ad; regBD = x.bd; regAE = x.ae; regBE = x.be;
    regScr_E = x.se; regw_E = x.rwe; regmem_E = x.rme; branch_E = x.br; taken_E = x.tk;
    regScr_M = x.sm; regw_M = x.rwm; vect_M = x.vm; memop_M = x.mm;
    regScr_W = x.sw; regw_W = x.rww;
  endtask

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // One clock cycle: drive just after the edge, sample mid-cycle, advance.
  task automatic cyc(input vec_t x);
    drive(x);
    #3;
    chk({x.name, " ctl"}, {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}, x.ctl);
    chk({x.name, " fwdA"}, {5'd0, fwdA_E}, {5'd0, x.fa});
    chk({x.name, " fwdB"}, {5'd0, fwdB_E}, {5'd0, x.fb});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_v1(input vec_t x, input logic [6:0] want1);
    drive(x);
    #3;
    chk({x.name, " v1 ctl"}, {s1_F, s1_D, s1_E, s1_M, f1_D, f1_E, f1_W}, want1);
    chk({x.name, " ctl"}, {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W}, x.ctl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    v = dflt("reset"); v.rst = 0; v.rwm = 1; v.sm = 7; v.ctl = C_RST; tbl.push_back(v);
    v = dflt("reset2"); v.rst = 0; v.vm = 1; v.mm = 1; v.ctl = C_RST; tbl.push_back(v);
    v = dflt("idle"); tbl.push_back(v);
    v = dflt("lu_a"); v.ad = 3; v.se = 3; v.rwe = 1; v.rme = 1; v.ctl = C_LU; tbl.push_back(v);
    v = dflt("lu_b"); v.bd = 3; v.se = 3; v.rwe = 1; v.rme = 1; v.ctl = C_LU; tbl.push_back(v);
    v = dflt("lu_nowr"); v.ad = 3; v.se = 3; v.rwe = 0; v.rme = 1; tbl.push_back(v);
    v = dflt("alu_dep"); v.ad = 3; v.se = 3; v.rwe = 1; v.rme = 0; tbl.push_back(v);
    v = dflt("lu_r0"); v.ad = 0; v.se = 0; v.rwe = 1; v.rme = 1; v.ctl = C_LU; tbl.push_back(v);
    v = dflt("fwd_mw"); v.sm = 5; v.rwm = 1; v.sw = 5; v.rww = 1; v.ae = 5; v.be = 6;
    v.fa = 2'b10; tbl.push_back(v);
    v = dflt("fwd_w"); v.sm = 5; v.rwm = 0; v.sw = 5; v.rww = 1; v.ae = 5; v.be = 6;
    v.fa = 2'b01; tbl.push_back(v);
    v = dflt("fwd_bw_am"); v.sm = 4; v.rwm = 1; v.sw = 6; v.rww = 1; v.ae = 4; v.be = 6;
    v.fa = 2'b10; v.fb = 2'b01; tbl.push_back(v);
    v = dflt("fwd_r0"); v.sm = 0; v.rwm = 1; v.ae = 0; v.be = 0; v.fa = 2'b10; v.fb = 2'b10;
    tbl.push_back(v);
    v = dflt("fwd_wr_off"); v.sw = 7; v.rww = 0; v.sm = 8; v.rwm = 0; tbl.push_back(v);
    v = dflt("br_lu"); v.br = 1; v.tk = 1; v.ad = 3; v.se = 3; v.rwe = 1; v.rme = 1;
    v.ctl = C_BR; tbl.push_back(v);
    v = dflt("br_nt"); v.br = 1; v.tk = 0; tbl.push_back(v);
    v = dflt("tk_nobr"); v.br = 0; v.tk = 1; tbl.push_back(v);
    v = dflt("mem_scalar"); v.mm = 1; v.vm = 0; tbl.push_back(v);
    v = dflt("vect_nomem"); v.mm = 0; v.vm = 1; tbl.push_back(v);

    drive(dflt("init"));
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // Load-use bubble, then the load sits in M and feeds the dependent op.
    v = dflt("seq_lu0"); v.ad = 3; v.se = 3; v.rwe = 1; v.rme = 1; v.ctl = C_LU; cyc(v);
    v = dflt("seq_lu1"); v.ad = 3; v.sm = 3; v.rwm = 1; v.ae = 3; v.fa = 2'b10; cyc(v);

    // Back-to-back vector ops held in M: stall 3, release, stall 3, release.
    for (int k = 0; k < 9; k++) begin
      v = dflt($sformatf("vm_b2b%0d", k));
      v.vm = (k < 8); v.mm = (k < 8);
      v.ctl = (k == 3 || k >= 7) ? C_NONE : C_VM;
      cyc_v1(v, C_NONE);
    end

    // Taken branch held during a vector hold only acts in the release cycle.
    for (int k = 0; k < 4; k++) begin
      v = dflt($sformatf("vm_br%0d", k));
      v.vm = 1; v.mm = 1; v.br = 1; v.tk = 1;
      v.ctl = (k < 3) ? C_VM : C_BR;
      cyc(v);
    end
    v = dflt("vm_br_done"); cyc(v);

    // Reset in the second stall cycle aborts; the still-present op restarts a full hold.
    for (int k = 0; k < 7; k++) begin
      v = dflt($sformatf("vm_rst%0d", k));
      v.vm = (k < 6); v.mm = (k < 6); v.rst = (k != 1);
      v.sm = 5; v.rwm = 1; v.ae = 5;
      v.fa = (k == 1) ? 2'b00 : 2'b10;
      case (k)
        0, 2, 3, 4: v.ctl = C_VM;
        1:          v.ctl = C_RST;
        default:    v.ctl = C_NONE;
      endcase
      cyc(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the vector processor. It generates the stall/flush controls consumed by the fetch, decode-execute, execute-memory and memory-writeback pipeline registers, and the operand forwarding selects for the execute stage. It resolves load-use hazards, taken branches and fixed-latency vector memory accesses, and sits alongside the datapath between the decode and writeback stages.

## Interface
- M, 4: register address width.
- VLAT, 4: vector memory access latency in cycles, ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- regAD, regBD  in  M  source register indices of the instruction in decode.
- regAE, regBE  in  M  source register indices of the instruction in execute.
- regScr_E  in  M  destination index in execute.
- regw_E, regmem_E  in  1  execute instruction writes a register / is a load.
- branch_E, taken_E  in  1  execute instruction is a branch / branch resolved taken.
- regScr_M, regw_M  in  M, 1  memory-stage destination and write enable.
- vect_M, memop_M  in  1  memory-stage instruction is vectorial / accesses memory.
- regScr_W, regw_W  in  M, 1  writeback-stage destination and write enable.
- stall_F, stall_D, stall_E, stall_M  out  1  hold the corresponding pipeline register (wen = ~stall).
- flush_D, flush_E, flush_W  out  1  clear the corresponding pipeline register.
- fwdA_E, fwdB_E  out  2  operand select: 00 register file, 01 writeback result, 10 memory-stage result.

## Operation
- FSM states: IDLE, BUSY. Down-counter cnt has width max(1, $clog2(VLAT)).
- vstart = state==IDLE & vect_M & memop_M & VLAT>1.
- IDLE:
  - If vstart: vmem stall this cycle, next state BUSY, cnt←VLAT-2.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt!=0: vmem stall, cnt←cnt-1.
  - If cnt==0: no vmem stall (release cycle), next state IDLE.
- Vmem stall: stall_F=stall_D=stall_E=stall_M=1, flush_W=1, and flush_D=flush_E=0. It overrides the load-use and branch conditions, which are re-evaluated after release because the E stage is held.
- When no vmem stall, branch and load-use are evaluated:
  - Branch: branch_E & taken_E gives flush_D=flush_E=1 for that cycle, with no stalls. It wins over a simultaneous load-use, because the decode instruction is discarded.
  - Load-use: regmem_E & regw_E & (regScr_E==regAD | regScr_E==regBD) gives stall_F=stall_D=1 and flush_E=1 (bubble), held for 1 cycle.
- Forwarding (combinational, independent of stalls), per source:
  - 10 if regw_M & regScr_M==regAE (resp. regBE).
  - Else 01 if regw_W & regScr_W matches.
  - Else 00.
  - The M stage wins when both M and W match.
- All register indices, including 0, participate in comparisons.
- While rst=0:
  - All stalls are 0, flush_D=flush_E=flush_W=1, and fwd=00.
  - Next state is IDLE with cnt=0; this aborts any in-progress vector access.

## Timing
- Stall and flush outputs are combinational from inputs and state; they act at the same clock edge.
- Vector memory op present in M at cycle t:
  - Stalls are asserted cycles t..t+VLAT-2 (VLAT-1 cycles).
  - The op advances to W at the edge ending cycle t+VLAT-1.
  - VLAT=1: never stalls.
- In the release cycle the same op is still in M, but state is BUSY, so it does not retrigger.
- Back-to-back vector memory ops: the second reaches M at t+VLAT and is seen in IDLE, so it starts a new count immediately with no dead cycle besides the release cycle.
- Load-use costs exactly 1 bubble. A taken branch costs 2 flushed slots.
- Reset asserted during BUSY: the outputs above apply in that cycle; IDLE from the next cycle.

## Test plan
- Load r3 in E, decode reads r3 via regAD -> stall_F=stall_D=flush_E=1 for one cycle; next cycle all 0 once the load moves to M, and fwdA_E=10 for the dependent instruction.
- regw_M with regScr_M=5, regw_W with regScr_W=5, regAE=5 -> fwdA_E=10; drop regw_M -> 01; regBE=6 -> fwdB_E=00.
- Taken branch in E with a simultaneous load-use match -> flush_D=flush_E=1 and stall_F=stall_D=0 for exactly 1 cycle.
- VLAT=4, vector load in M at cycle 10:
  - stall_F..stall_M=1 and flush_W=1 for cycles 10,11,12.
  - Cycle 13: all 0, and the op reaches W at cycle 14.
  - A second vector op in M at 14 stalls 14..16.
- VLAT=4, taken branch in E during a vmem stall -> flush_D/flush_E stay 0 until the release cycle, then assert for 1 cycle.
- rst=0 at cycle 11 of a vmem stall -> stalls 0 and flush_D/E/W=1 that cycle; after rst=1, state is IDLE, and with vect_M and memop_M held high a new 3-cycle stall begins.
